chip8_fb_streamer: RTL

//   Reader side of the CHIP-8 framebuffer. It snapshots the 2048-bit 64x32 display vector on request.
//   It then streams the snapshot as packed pixel bytes over a valid/ready interface.
//   It sits between the top-level display output and a panel/serial driver (OLED SPI, UART dump, VGA line buffer).
//   A snapshot keeps a whole frame coherent while the CPU keeps drawing.

---
 rtl/chip8_fb_streamer.sv | 130 +++++++++++++
 1 files changed

// File: rtl/chip8_fb_streamer.sv
// Snapshots the 64x32 CHIP-8 framebuffer on request and streams it as packed
// pixel bytes (bit7 = leftmost pixel) over a valid/ready interface.
module chip8_fb_streamer #(
    parameter int ROW_REPEAT = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [2047:0] display,
    input  logic          frame_req,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [7:0]    out_data,
    output logic          out_first,
    output logic          out_last,
    output logic          busy,
    output logic          frame_done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_e;

    localparam logic [1:0] REP_MAX = 2'(ROW_REPEAT - 1);

    state_e        state_q, state_d;
    logic [2047:0] snap_q, snap_d;
    logic [2:0]    col_q, col_d;
    logic [1:0]    rep_q, rep_d;
    logic [4:0]    y_q, y_d;
    logic          pending_q, pending_d;

    logic          handshake;
    logic          capture;
    logic [10:0]   base;
    logic [7:0]    raw;

    always_comb begin
        out_valid  = (state_q == STREAM);
        busy       = (state_q != IDLE);
        frame_done = (state_q == DONE);
        out_first  = out_valid && (y_q == 5'd0) && (rep_q == 2'd0) && (col_q == 3'd0);
        out_last   = out_valid && (y_q == 5'd31) && (rep_q == REP_MAX) && (col_q == 3'd7);

        // Byte (y, col) starts at display bit y*64 + col*8; lowest x goes to bit7.
        base = {y_q, col_q, 3'b000};
        raw  = snap_q[base +: 8];
        out_data = '0;
        if (out_valid) begin
            out_data = {raw[0], raw[1], raw[2], raw[3], raw[4], raw[5], raw[6], raw[7]};
        end
    end

    always_comb begin
        state_d   = state_q;
        snap_d    = snap_q;
        col_d     = col_q;
        rep_d     = rep_q;
        y_d       = y_q;
        pending_d = pending_q;
        capture   = 1'b0;
        handshake = out_valid && out_ready;

        case (state_q)
            IDLE: begin
                if (frame_req) begin
                    capture = 1'b1;
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (frame_req) begin
                    pending_d = 1'b1;
                end
                if (handshake) begin
                    col_d = col_q + 3'd1;
                    if (col_q == 3'd7) begin
                        if (rep_q == REP_MAX) begin
                            rep_d = '0;
                            y_d   = y_q + 5'd1;
                        end else begin
                            rep_d = rep_q + 2'd1;
                        end
                    end
                    if (out_last) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                // A request arriving during DONE itself is honoured here rather
                // than being left pending in IDLE.
                if (pending_q || frame_req) begin
                    capture   = 1'b1;
                    pending_d = 1'b0;
                    state_d   = STREAM;
                end else begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (capture) begin
            snap_d = display;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            snap_q    <= '0;
            col_q     <= '0;
            rep_q     <= '0;
            y_q       <= '0;
            pending_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            snap_q    <= snap_d;
            col_q     <= col_d;
            rep_q     <= rep_d;
            y_q       <= y_d;
            pending_q <= pending_d;
        end
    end

endmodule
